// File: rtl/lfsr_sweep_generator_if.sv
// rtl/lfsr_sweep_generator_if.sv - request/report bundle between a sweep controller and lfsr_sweep_generator
interface lfsr_sweep_generator_if;
  logic [23:0] ts_now;
  logic        start;
  logic        poly_sel;
  logic [16:0] seed;
  logic [16:0] length;
  logic        busy;
  logic        done;
  logic        err;
  logic        chip_strobe;
  logic        data_out;
  logic [16:0] value;
  logic [16:0] iteration_number;
  logic [23:0] ts_start;

  modport master (
    output ts_now, start, poly_sel, seed, length,
    input  busy, done, err, chip_strobe, data_out, value, iteration_number, ts_start
  );

  modport slave (
    input  ts_now, start, poly_sel, seed, length,
    output busy, done, err, chip_strobe, data_out, value, iteration_number, ts_start
  );
endinterface

// File: rtl/lfsr_sweep_generator.sv
// rtl/lfsr_sweep_generator.sv - seeded 17-bit LFSR chip emitter; BMC_ENCODE_EN selects biphase-mark line coding
module lfsr_sweep_generator #(
  parameter int unsigned CHIP_DIV = 16,
  parameter logic [16:0] POLY_A   = 17'h1d258,
  parameter logic [16:0] POLY_B   = 17'h17e04
) (
  input  logic                   clk_96MHz,
  input  logic                   reset,
  lfsr_sweep_generator_if.slave  sweep
);
  localparam int unsigned      DIV_W    = $clog2(CHIP_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CHIP_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CHIP_DIV / 2);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic             first_q;
  logic [16:0]      seed_q;
  logic [16:0]      poly_q;
  logic [16:0]      len_q;
  logic [16:0]      value_q;
  logic [16:0]      iter_q;
  logic [23:0]      ts_start_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             strobe_q;
  logic             data_q;
  logic [16:0]      lfsr_d;
  logic             last_chip;

  assign lfsr_d    = {value_q[15:0], ^(value_q & poly_q)};
  assign last_chip = (iter_q == len_q - 17'd1);

`ifndef BMC_ENCODE_EN
  // Chip 0 emits the seed itself; later chips emit the freshly stepped state.
  logic chip_bit;
  assign chip_bit = first_q ? value_q[16] : lfsr_d[16];
`endif

  always_ff @(posedge clk_96MHz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      first_q    <= 1'b0;
      seed_q     <= '0;
      poly_q     <= '0;
      len_q      <= '0;
      value_q    <= '0;
      iter_q     <= '0;
      ts_start_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      strobe_q   <= 1'b0;
      data_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sweep.start) begin
            seed_q <= sweep.seed;
            poly_q <= sweep.poly_sel ? POLY_B : POLY_A;
            len_q  <= sweep.length;
            if (sweep.seed == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (sweep.length == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          value_q    <= seed_q;
          iter_q     <= '0;
          ts_start_q <= sweep.ts_now;
          busy_q     <= 1'b1;
          div_q      <= '0;
          first_q    <= 1'b1;
          data_q     <= 1'b0;
          state_q    <= RUN;
        end
        RUN: begin
          div_q    <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
          strobe_q <= 1'b0;
          if (div_q == '0) begin
            // The chip-boundary edge either finishes the sweep or opens the next chip.
            if (!first_q && last_chip) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              data_q  <= 1'b0;
            end else begin
              strobe_q <= 1'b1;
              first_q  <= 1'b0;
              if (!first_q) begin
                value_q <= lfsr_d;
                iter_q  <= iter_q + 17'd1;
              end
`ifdef BMC_ENCODE_EN
              data_q <= ~data_q;
`else
              data_q <= chip_bit;
`endif
            end
          end
`ifdef BMC_ENCODE_EN
          else if (div_q == DIV_HALF && value_q[16]) begin
            data_q <= ~data_q;
          end
`endif
        end
        DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sweep.busy             = busy_q;
  assign sweep.done             = done_q;
  assign sweep.err              = err_q;
  assign sweep.chip_strobe      = strobe_q;
  assign sweep.data_out         = data_q;
  assign sweep.value            = value_q;
  assign sweep.iteration_number = iter_q;
  assign sweep.ts_start         = ts_start_q;
endmodule
